// File: rtl/csr_sequencer_if.sv
// Control signals between the CSR access sequencer (master) and the CSR file (slave).
// The shared data bus is a separate inout net on the sequencer; this interface carries the strobes only.
interface csr_sequencer_if #(
  parameter int ADDR_W  = 12,
  parameter int CAUSE_W = 5
);
  // Strobe protocol: each of csr_read/csr_write/csr_trap/csr_ret is high for exactly one cycle
  // and is a complete transfer on its own (no ready/backpressure). csr_addr and csr_write_type
  // are stable for that cycle, and csr_invalid is answered combinationally in the same cycle.
  logic [ADDR_W-1:0]  csr_addr;
  logic               csr_read;
  logic               csr_write;
  logic [1:0]         csr_write_type;
  logic               csr_trap;
  logic [CAUSE_W-1:0] csr_trap_cause;
  logic               csr_ret;
  logic               csr_invalid;

  modport master (
    output csr_addr, csr_read, csr_write, csr_write_type,
    output csr_trap, csr_trap_cause, csr_ret,
    input  csr_invalid
  );

  modport slave (
    input  csr_addr, csr_read, csr_write, csr_write_type,
    input  csr_trap, csr_trap_cause, csr_ret,
    output csr_invalid
  );
endinterface

// File: rtl/csr_sequencer.sv
// Initiator side of the CSR access port: sequences Zicsr read/write phases, trap entry and mret.
// Optional build macro CSR_SEQ_RO_CHECK_EN: never issue a write phase into read-only CSR space.
module csr_sequencer #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int CAUSE_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [2:0]         i_funct3,
  input  logic [ADDR_W-1:0]  i_addr_in,
  input  logic [DATA_W-1:0]  i_rs1_val,
  input  logic [4:0]         i_zimm,
  input  logic               i_rd_is_zero,
  input  logic               i_rs1_is_zero,
  input  logic               i_trap_req,
  input  logic [CAUSE_W-1:0] i_trap_cause_in,
  input  logic [DATA_W-1:0]  i_trap_pc,
  input  logic               i_ret_req,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_illegal,
  output logic               o_rd_we,
  output logic [DATA_W-1:0]  o_rd_val,
  output logic [2:0]         o_state,
  inout  wire  [DATA_W-1:0]  io_csr_bus,
  csr_sequencer_if.master    csr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_FIN   = 3'd3,
    S_TRAP  = 3'd4,
    S_RET   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [ADDR_W-1:0]  r_addr;
  logic [1:0]         r_wtype;
  logic [DATA_W-1:0]  r_operand;
  logic [DATA_W-1:0]  r_pc;
  logic [DATA_W-1:0]  r_rd_val;
  logic [CAUSE_W-1:0] r_cause;
  logic               r_rd_zero;
  logic               r_no_write;
  logic               r_read_done;
  logic               r_illegal;

  logic               w_bad_f3;
  logic               w_skip_read;
  logic               w_skip_write;
  logic               w_ro_space;
  logic [DATA_W-1:0]  w_operand;
  logic               w_drive_en;
  logic [DATA_W-1:0]  w_drive_val;
  logic               w_read;
  logic               w_write;
  logic               w_trap;
  logic               w_ret;
  logic               w_fin;

  // funct3[1:0]==00 is not a Zicsr encoding; it is retired as illegal without touching the CSR file.
  assign w_bad_f3     = (i_funct3[1:0] == 2'b00);
  assign w_skip_read  = (i_funct3[1:0] == 2'b01) & i_rd_is_zero;
  assign w_skip_write = (i_funct3[1:0] != 2'b01) & i_rs1_is_zero;
  assign w_operand    = i_funct3[2] ? {{(DATA_W-5){1'b0}}, i_zimm} : i_rs1_val;

`ifdef CSR_SEQ_RO_CHECK_EN
  assign w_ro_space = (i_addr_in[ADDR_W-1 -: 2] == 2'b11);
`else
  assign w_ro_space = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_read  = 1'b0;
    w_write = 1'b0;
    w_trap  = 1'b0;
    w_ret   = 1'b0;
    w_fin   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_trap_req)      w_next = S_TRAP;
        else if (i_ret_req)  w_next = S_RET;
        else if (i_start) begin
          if (w_bad_f3)                      w_next = S_FIN;
          else if (!w_skip_read)             w_next = S_READ;
          else if (w_skip_write | w_ro_space) w_next = S_FIN;
          else                               w_next = S_WRITE;
        end
      end
      S_READ: begin
        w_read = 1'b1;
        w_next = (csr.csr_invalid | r_no_write) ? S_FIN : S_WRITE;
      end
      S_WRITE: begin
        w_write = 1'b1;
        w_next  = S_FIN;
      end
      S_TRAP: begin
        w_trap = 1'b1;
        w_next = S_FIN;
      end
      S_RET: begin
        w_ret  = 1'b1;
        w_next = S_FIN;
      end
      S_FIN: begin
        w_fin  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_wtype     <= '0;
      r_operand   <= '0;
      r_pc        <= '0;
      r_rd_val    <= '0;
      r_cause     <= '0;
      r_rd_zero   <= 1'b0;
      r_no_write  <= 1'b0;
      r_read_done <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_read_done <= 1'b0;
          r_illegal   <= 1'b0;
          if (i_trap_req) begin
            r_cause <= i_trap_cause_in;
            r_pc    <= i_trap_pc;
          end else if (!i_ret_req && i_start) begin
            r_addr     <= i_addr_in;
            r_wtype    <= i_funct3[1:0];
            r_operand  <= w_operand;
            r_rd_zero  <= i_rd_is_zero;
            r_no_write <= w_skip_write | w_ro_space;
            r_illegal  <= w_bad_f3 | (w_ro_space & ~w_skip_write);
          end
        end
        S_READ: begin
          // An unknown address leaves rd_val untouched; the bus is undriven in that case.
          if (csr.csr_invalid) r_illegal <= 1'b1;
          else begin
            r_rd_val    <= io_csr_bus;
            r_read_done <= 1'b1;
          end
        end
        S_WRITE: begin
          if (csr.csr_invalid) r_illegal <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The bus is owned only in WRITE and TRAP, so it is never driven while csr_read is high.
  assign w_drive_en  = w_write | w_trap;
  assign w_drive_val = w_trap ? r_pc : r_operand;
  assign io_csr_bus  = w_drive_en ? w_drive_val : {DATA_W{1'bz}};

  assign csr.csr_addr       = r_addr;
  assign csr.csr_read       = w_read;
  assign csr.csr_write      = w_write;
  assign csr.csr_write_type = w_write ? r_wtype : 2'b00;
  assign csr.csr_trap       = w_trap;
  assign csr.csr_trap_cause = w_trap ? r_cause : '0;
  assign csr.csr_ret        = w_ret;

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = w_fin;
  assign o_illegal = w_fin & r_illegal;
  assign o_rd_we   = w_fin & r_read_done & ~r_rd_zero & ~r_illegal;
  assign o_rd_val  = r_rd_val;
  assign o_state   = r_state;

endmodule

// File: tb/tb_csr_sequencer.sv
// Directed bench for csr_sequencer: a small CSR file model answers the port, and a per-cycle
// expectation queue built from the access rules is compared against the DUT outputs.
module tb_csr_sequencer;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [2:0]  i_funct3;
  logic [11:0] i_addr_in;
  logic [31:0] i_rs1_val;
  logic [4:0]  i_zimm;
  logic        i_rd_is_zero;
  logic        i_rs1_is_zero;
  logic        i_trap_req;
  logic [4:0]  i_trap_cause_in;
  logic [31:0] i_trap_pc;
  logic        i_ret_req;
  logic        o_busy;
  logic        o_done;
  logic        o_illegal;
  logic        o_rd_we;
  logic [31:0] o_rd_val;
  logic [2:0]  dbg_state;
  wire  [31:0] csr_bus;

  csr_sequencer_if #(.ADDR_W(12), .CAUSE_W(5)) ifc ();

  csr_sequencer #(.DATA_W(32), .ADDR_W(12), .CAUSE_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_funct3        (i_funct3),
    .i_addr_in       (i_addr_in),
    .i_rs1_val       (i_rs1_val),
    .i_zimm          (i_zimm),
    .i_rd_is_zero    (i_rd_is_zero),
    .i_rs1_is_zero   (i_rs1_is_zero),
    .i_trap_req      (i_trap_req),
    .i_trap_cause_in (i_trap_cause_in),
    .i_trap_pc       (i_trap_pc),
    .i_ret_req       (i_ret_req),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_illegal       (o_illegal),
    .o_rd_we         (o_rd_we),
    .o_rd_val        (o_rd_val),
    .o_state         (dbg_state),
    .io_csr_bus      (csr_bus),
    .csr             (ifc.master)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- CSR file environment ----------------
  logic [31:0] env_mem [0:4095];
  int          wr_cnt;

  function automatic bit is_known(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h340) || (a == 12'h341) ||
           (a == 12'h342) || (a == 12'hF14);
  endfunction

  function automatic logic [31:0] apply_op(input logic [1:0] t, input logic [31:0] old_v,
                                           input logic [31:0] opnd);
    case (t)
      2'b01:   return opnd;
      2'b10:   return old_v | opnd;
      2'b11:   return old_v & ~opnd;
      default: return old_v;
    endcase
  endfunction

  assign ifc.csr_invalid = (ifc.csr_read | ifc.csr_write) & !is_known(ifc.csr_addr);
  assign csr_bus = (ifc.csr_read && is_known(ifc.csr_addr)) ? env_mem[ifc.csr_addr] : 32'bz;

  always @(posedge clk) begin
    if (rst) begin
      env_mem[12'h300] <= 32'h0000_1888;
      env_mem[12'h340] <= 32'h0000_0011;
      env_mem[12'h341] <= 32'h0000_000F;
      env_mem[12'h342] <= 32'h0000_0000;
      env_mem[12'hF14] <= 32'h0000_0000;
      wr_cnt <= 0;
    end else begin
      if (ifc.csr_write) begin
        wr_cnt <= wr_cnt + 1;
        if (is_known(ifc.csr_addr) && ifc.csr_addr[11:10] != 2'b11)
          env_mem[ifc.csr_addr] <= apply_op(ifc.csr_write_type, env_mem[ifc.csr_addr], csr_bus);
      end
      if (ifc.csr_trap) begin
        env_mem[12'h341] <= csr_bus;
        env_mem[12'h342] <= {27'd0, ifc.csr_trap_cause};
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        illegal;
    logic        rd_we;
    logic        rd;
    logic        wr;
    logic [1:0]  wtype;
    logic        trap;
    logic        ret;
    logic [4:0]  cause;
    logic [11:0] addr;
    logic        bus_chk;
    logic [31:0] bus;
    logic [31:0] rd_val;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  logic [31:0]      ref_mem [0:4095];
  logic [31:0]      m_rd_val;
  int               checks;
  int               failures;
  bit               chk_on;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic req);
    chk32(name, {31'd0, act}, {31'd0, req});
  endtask

  task automatic ref_reset();
    ref_mem[12'h300] = 32'h0000_1888;
    ref_mem[12'h340] = 32'h0000_0011;
    ref_mem[12'h341] = 32'h0000_000F;
    ref_mem[12'h342] = 32'h0000_0000;
    ref_mem[12'hF14] = 32'h0000_0000;
  endtask

  function automatic exp_t idle_rec();
    exp_t e;
    e = '0;
    e.rd_val = m_rd_val;
    return e;
  endfunction

  // Expected cycle-by-cycle activity of one Zicsr instruction, derived from the access rules.
  task automatic model_csr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                           input logic [4:0] zi, input bit rdz, input bit rs1z, output int len);
    exp_t        e;
    logic [31:0] opnd;
    logic [31:0] old_v;
    bit          known, do_rd, do_wr, ill, got_old;
    opnd    = f3[2] ? {27'd0, zi} : rs1;
    known   = is_known(a);
    old_v   = ref_mem[a];
    do_rd   = !((f3[1:0] == 2'b01) && rdz);
    do_wr   = !((f3[1:0] != 2'b01) && rs1z);
    ill     = 1'b0;
    got_old = 1'b0;
    len     = 0;
    if (do_rd) begin
      e = idle_rec();
      e.busy = 1'b1; e.rd = 1'b1; e.addr = a;
      e.bus_chk = known; e.bus = old_v;
      exp_q.push_back(e);
      len++;
      if (!known) begin
        ill   = 1'b1;
        do_wr = 1'b0;
      end else begin
        m_rd_val = old_v;
        got_old  = 1'b1;
      end
    end
`ifdef CSR_SEQ_RO_CHECK_EN
    if (do_wr && a[11:10] == 2'b11) begin
      ill   = 1'b1;
      do_wr = 1'b0;
    end
`endif
    if (do_wr) begin
      e = idle_rec();
      e.busy = 1'b1; e.wr = 1'b1; e.wtype = f3[1:0]; e.addr = a;
      e.bus_chk = 1'b1; e.bus = opnd;
      exp_q.push_back(e);
      len++;
      if (!known) ill = 1'b1;
      else if (a[11:10] != 2'b11) ref_mem[a] = apply_op(f3[1:0], old_v, opnd);
    end
    e = idle_rec();
    e.busy = 1'b1; e.done = 1'b1; e.illegal = ill;
    e.rd_we = !rdz && !ill && got_old;
    exp_q.push_back(e);
    len++;
  endtask

  task automatic model_trap(input logic [4:0] cause, input logic [31:0] pc, output int len);
    exp_t e;
    e = idle_rec();
    e.busy = 1'b1; e.trap = 1'b1; e.cause = cause; e.bus_chk = 1'b1; e.bus = pc;
    exp_q.push_back(e);
    ref_mem[12'h341] = pc;
    ref_mem[12'h342] = {27'd0, cause};
    e = idle_rec();
    e.busy = 1'b1; e.done = 1'b1;
    exp_q.push_back(e);
    len = 2;
  endtask

  task automatic model_ret(output int len);
    exp_t e;
    e = idle_rec();
    e.busy = 1'b1; e.ret = 1'b1;
    exp_q.push_back(e);
    e = idle_rec();
    e.busy = 1'b1; e.done = 1'b1;
    exp_q.push_back(e);
    len = 2;
  endtask

  always @(negedge clk) begin : compare
    exp_t e;
    if (chk_on) begin
      if (exp_q.size() > 0) e = exp_t'(exp_q.pop_front());
      else                  e = idle_rec();
      chk_b("busy", o_busy, e.busy);
      chk_b("done", o_done, e.done);
      if (e.done) begin
        chk_b("illegal", o_illegal, e.illegal);
        chk_b("rd_we", o_rd_we, e.rd_we);
      end
      chk32("rd_val", o_rd_val, e.rd_val);
      chk_b("csr_read", ifc.csr_read, e.rd);
      chk_b("csr_write", ifc.csr_write, e.wr);
      chk_b("csr_trap", ifc.csr_trap, e.trap);
      chk_b("csr_ret", ifc.csr_ret, e.ret);
      if (e.rd || e.wr) chk32("csr_addr", 32'(ifc.csr_addr), 32'(e.addr));
      if (e.wr)         chk32("write_type", 32'(ifc.csr_write_type), 32'(e.wtype));
      if (e.trap)       chk32("trap_cause", 32'(ifc.csr_trap_cause), 32'(e.cause));
      if (e.bus_chk)    chk32("csr_bus", csr_bus, e.bus);
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input bit trap, input bit ret, input bit st, input logic [2:0] f3,
                        input logic [11:0] a, input logic [31:0] rs1, input logic [4:0] zi,
                        input bit rdz, input bit rs1z, input logic [4:0] cause,
                        input logic [31:0] pc, input bit poke, output int len);
    @(posedge clk); #1;
    i_trap_req = trap; i_ret_req = ret; i_start = st;
    i_funct3 = f3; i_addr_in = a; i_rs1_val = rs1; i_zimm = zi;
    i_rd_is_zero = rdz; i_rs1_is_zero = rs1z;
    i_trap_cause_in = cause; i_trap_pc = pc;
    @(posedge clk); #1;
    i_trap_req = 1'b0; i_ret_req = 1'b0; i_start = 1'b0;
    if (trap)     model_trap(cause, pc, len);
    else if (ret) model_ret(len);
    else          model_csr(f3, a, rs1, zi, rdz, rs1z, len);
    if (poke) begin
      // Requests raised while busy must be ignored.
      i_start = 1'b1; i_trap_req = 1'b1; i_ret_req = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0; i_trap_req = 1'b0; i_ret_req = 1'b0;
      repeat (len - 1) @(posedge clk);
    end else begin
      repeat (len) @(posedge clk);
    end
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int len;
    checks = 0; failures = 0; chk_on = 1'b0;
    rst = 1'b1;
    i_start = 1'b0; i_funct3 = 3'd0; i_addr_in = 12'd0; i_rs1_val = 32'd0; i_zimm = 5'd0;
    i_rd_is_zero = 1'b0; i_rs1_is_zero = 1'b0; i_trap_req = 1'b0; i_trap_cause_in = 5'd0;
    i_trap_pc = 32'd0; i_ret_req = 1'b0;
    ref_reset();
    m_rd_val = 32'd0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    chk_on = 1'b1;
    chk_b("rst_busy", o_busy, 1'b0);
    chk_b("rst_done", o_done, 1'b0);
    chk32("rst_rd_val", o_rd_val, 32'h0);
    chk_b("rst_csr_write", ifc.csr_write, 1'b0);

    // CSRRW 0x340 <- 0xDEADBEEF, old mscratch 0x11
    run_op(0, 0, 1, 3'b001, 12'h340, 32'hDEAD_BEEF, 5'd0, 0, 0, 5'd0, 32'd0, 0, len);
    chk32("rw_len", 32'(len), 32'd3);
    chk32("rw_rd_val", o_rd_val, 32'h11);
    chk32("rw_mscratch", env_mem[12'h340], 32'hDEAD_BEEF);

    // CSRRS 0x300 rs1=x0: read only
    run_op(0, 0, 1, 3'b010, 12'h300, 32'd0, 5'd0, 0, 1, 5'd0, 32'd0, 0, len);
    chk32("rs0_len", 32'(len), 32'd2);
    chk32("rs0_rd_val", o_rd_val, 32'h1888);
    chk32("rs0_wr_cnt", 32'(wr_cnt), 32'd1);

    // CSRRCI 0x341 zimm=3, mepc 0xF -> 0xC
    run_op(0, 0, 1, 3'b111, 12'h341, 32'd0, 5'd3, 0, 0, 5'd0, 32'd0, 0, len);
    chk32("rci_len", 32'(len), 32'd3);
    chk32("rci_mepc", env_mem[12'h341], 32'hC);
    chk32("rci_rd_val", o_rd_val, 32'hF);

    // CSRRW to unknown 0x7C0: faults in READ, no write
    run_op(0, 0, 1, 3'b001, 12'h7C0, 32'h1234, 5'd0, 0, 0, 5'd0, 32'd0, 0, len);
    chk32("inv_len", 32'(len), 32'd2);
    chk32("inv_wr_cnt", 32'(wr_cnt), 32'd2);

    // trap_req and start together: trap wins, start dropped
    run_op(1, 0, 1, 3'b001, 12'h340, 32'h5555, 5'd0, 0, 0, 5'd2, 32'h80, 0, len);
    chk32("trap_len", 32'(len), 32'd2);
    chk32("trap_mepc", env_mem[12'h341], 32'h80);
    chk32("trap_mcause", env_mem[12'h342], 32'h2);
    chk32("trap_wr_cnt", 32'(wr_cnt), 32'd2);

    // mret, then ret_req and start together
    run_op(0, 1, 0, 3'b000, 12'h000, 32'd0, 5'd0, 0, 0, 5'd0, 32'd0, 0, len);
    chk32("ret_len", 32'(len), 32'd2);
    run_op(0, 1, 1, 3'b010, 12'h300, 32'hFF, 5'd0, 0, 0, 5'd0, 32'd0, 0, len);
    chk32("ret_start_wr_cnt", 32'(wr_cnt), 32'd2);

    // CSRRWI rd=x0: write only
    run_op(0, 0, 1, 3'b101, 12'h340, 32'd0, 5'h1F, 1, 0, 5'd0, 32'd0, 0, len);
    chk32("rwi_len", 32'(len), 32'd2);
    chk32("rwi_mscratch", env_mem[12'h340], 32'h1F);
    chk32("rwi_rd_val", o_rd_val, 32'hF);

    // CSRRSI 0x300 zimm=5
    run_op(0, 0, 1, 3'b110, 12'h300, 32'd0, 5'd5, 0, 0, 5'd0, 32'd0, 0, len);
    chk32("rsi_mstatus", env_mem[12'h300], 32'h188D);
    chk32("rsi_rd_val", o_rd_val, 32'h1888);

    // CSRRC 0x342 rs1=3, mcause 2 -> 0
    run_op(0, 0, 1, 3'b011, 12'h342, 32'h3, 5'd0, 0, 0, 5'd0, 32'd0, 0, len);
    chk32("rc_mcause", env_mem[12'h342], 32'h0);
    chk32("rc_rd_val", o_rd_val, 32'h2);

    // CSRRS with requests poked while busy
    run_op(0, 0, 1, 3'b010, 12'h340, 32'h100, 5'd0, 0, 0, 5'd0, 32'd0, 1, len);
    chk32("busy_mscratch", env_mem[12'h340], 32'h11F);
    chk32("busy_wr_cnt", 32'(wr_cnt), 32'd6);

    // CSRRW into read-only space 0xF14
    run_op(0, 0, 1, 3'b001, 12'hF14, 32'h55, 5'd0, 0, 0, 5'd0, 32'd0, 0, len);
`ifdef CSR_SEQ_RO_CHECK_EN
    chk32("ro_len", 32'(len), 32'd2);
    chk32("ro_wr_cnt", 32'(wr_cnt), 32'd6);
`else
    chk32("ro_len", 32'(len), 32'd3);
    chk32("ro_wr_cnt", 32'(wr_cnt), 32'd7);
`endif
    chk32("ro_mhartid", env_mem[12'hF14], 32'h0);

    // Reset asserted during the WRITE phase of a CSRRW
    @(posedge clk); #1;
    i_start = 1'b1; i_funct3 = 3'b001; i_addr_in = 12'h342; i_rs1_val = 32'hAA;
    i_rd_is_zero = 1'b0; i_rs1_is_zero = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    model_csr(3'b001, 12'h342, 32'hAA, 5'd0, 0, 0, len);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_rd_val = 32'd0;
    ref_reset();
    chk_b("mid_rst_busy", o_busy, 1'b0);
    chk_b("mid_rst_done", o_done, 1'b0);
    chk_b("mid_rst_write", ifc.csr_write, 1'b0);
    chk_b("mid_rst_read", ifc.csr_read, 1'b0);
    chk32("mid_rst_rd_val", o_rd_val, 32'h0);
    repeat (2) @(posedge clk); #1;

    // Normal operation after reset: CSRRS 0x340 rs1=x0 reads the reset value
    run_op(0, 0, 1, 3'b010, 12'h340, 32'd0, 5'd0, 0, 1, 5'd0, 32'd0, 0, len);
    chk32("post_rst_rd_val", o_rd_val, 32'h11);

    repeat (3) @(posedge clk); #1;
    chk32("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
